// File: rtl/crb_load_pkg.sv
// Shared constants and types for the Crazy Balloon ROM/DIP download controller.
package crb_load_pkg;

  // Region bases within the index-0 image; ROM_TOP is the exclusive upper limit.
  localparam logic [15:0] CPU_BASE = 16'h0000;
  localparam logic [15:0] CHR_BASE = 16'h3000;
  localparam logic [15:0] SPR_BASE = 16'h3800;
  localparam logic [15:0] ROM_TOP  = 16'h4000;

  // Download index values issued by hps_io.
  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_DIP = 8'd254;

  // Bit positions in the one-hot region vector.
  localparam int unsigned REG_CPU = 0;
  localparam int unsigned REG_CHR = 1;
  localparam int unsigned REG_SPR = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    ERR    = 3'd4
  } ld_state_t;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational map from a download byte address to ROM region, local offset and validity.
module rom_region_decode
  import crb_load_pkg::*;
#(
  parameter int unsigned EXP_BYTES = 16'h4000
) (
  input  logic [24:0] i_addr,
  output logic [2:0]  o_region,
  output logic [13:0] o_offset,
  output logic        o_in_range
);

  localparam logic [16:0] Limit = 17'(EXP_BYTES);

  logic [15:0] w_lo;
  logic [15:0] w_base;

  assign w_lo = i_addr[15:0];

  // Pick the region, subtract its base, and suppress everything outside the image.
  always_comb begin
    o_region = 3'b000;
    w_base   = CPU_BASE;
    if (w_lo < CHR_BASE) begin
      o_region[REG_CPU] = 1'b1;
      w_base            = CPU_BASE;
    end else if (w_lo < SPR_BASE) begin
      o_region[REG_CHR] = 1'b1;
      w_base            = CHR_BASE;
    end else begin
      o_region[REG_SPR] = 1'b1;
      w_base            = SPR_BASE;
    end
    o_in_range = (i_addr[24:16] == 9'd0) && ({1'b0, w_lo} < Limit) && (w_lo < ROM_TOP);
    if (!o_in_range) begin
      o_region = 3'b000;
    end
    o_offset = 14'(w_lo - w_base);
  end

endmodule

// File: rtl/rom_load_ctrl.sv
// Steers the hps_io download stream into ROM region strobes and DIP registers, and holds
// the core in reset until a complete ROM image has loaded and settled.
module rom_load_ctrl
  import crb_load_pkg::*;
#(
  parameter int unsigned EXP_BYTES   = 16'h4000,
  parameter int unsigned HOLD_CYCLES = 256,
  parameter logic [7:0]  DIP_DEFAULT = 8'hFF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        dn_ld,
  input  logic        dn_wr,
  input  logic [7:0]  dn_index,
  input  logic [24:0] dn_addr,
  input  logic [7:0]  dn_data,
  output logic        cpu_rom_we,
  output logic        chr_rom_we,
  output logic        spr_rom_we,
  output logic [13:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [7:0]  dipsw1,
  output logic [7:0]  dipsw2,
  output logic        core_reset,
  output logic        load_ok,
  output logic        load_err
);

  localparam logic [16:0] ExpCnt = 17'(EXP_BYTES);
  localparam logic [16:0] CntMax = '1;

  ld_state_t   r_state;
  ld_state_t   w_state_d;
  logic        r_ld;
  logic        r_ld_prev;
  logic [7:0]  r_idx;
  logic [16:0] r_cnt;
  logic [31:0] r_hold;
  logic [2:0]  r_we;
  logic [13:0] r_rom_addr;
  logic [7:0]  r_rom_data;
  logic [7:0]  r_dip1;
  logic [7:0]  r_dip2;
  logic        r_load_ok;
  logic        r_load_err;

  logic [2:0]  w_region;
  logic [13:0] w_offset;
  logic        w_in_range;
  logic        w_rom_wr;
  logic        w_dip_wr;
  logic        w_rise;
  logic        w_fall;
  logic        w_enter_load;

  rom_region_decode #(
    .EXP_BYTES (EXP_BYTES)
  ) u_decode (
    .i_addr     (dn_addr),
    .o_region   (w_region),
    .o_offset   (w_offset),
    .o_in_range (w_in_range)
  );

  assign w_rom_wr = dn_wr && (dn_index == IDX_ROM) && w_in_range;
  assign w_dip_wr = dn_wr && (dn_index == IDX_DIP) && (dn_addr[24:3] == 22'd0);

  // Edges come from the registered copy so they are seen one cycle after dn_ld moves.
  assign w_rise       = r_ld && !r_ld_prev && (r_idx == IDX_ROM);
  assign w_fall       = !r_ld && r_ld_prev;
  assign w_enter_load = (w_state_d == LOAD) && (r_state != LOAD);

  // Next-state logic for the load sequencer.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE, RUN, ERR: if (w_rise) w_state_d = LOAD;
      LOAD:           if (w_fall) w_state_d = (r_cnt >= ExpCnt) ? SETTLE : ERR;
      SETTLE:         if (r_hold == HOLD_CYCLES) w_state_d = RUN;
      default:        w_state_d = IDLE;
    endcase
  end

  // State, dn_ld history and the settle timer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_ld      <= 1'b0;
      r_ld_prev <= 1'b0;
      r_idx     <= 8'd0;
      r_hold    <= 32'd0;
    end else begin
      r_state   <= w_state_d;
      r_ld      <= dn_ld;
      r_ld_prev <= r_ld;
      r_idx     <= dn_index;
      r_hold    <= (r_state == SETTLE) ? r_hold + 32'd1 : 32'd0;
    end
  end

  // Saturating byte counter; a byte landing on the LOAD entry cycle still counts.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_cnt <= 17'd0;
    end else if (w_enter_load) begin
      r_cnt <= w_rom_wr ? 17'd1 : 17'd0;
    end else if (w_rom_wr && (r_cnt != CntMax)) begin
      r_cnt <= r_cnt + 17'd1;
    end
  end

  // Load result flags, cleared whenever a new load starts.
  always_ff @(posedge CLK) begin
    if (RESET || w_enter_load) begin
      r_load_ok  <= 1'b0;
      r_load_err <= 1'b0;
    end else if ((r_state == LOAD) && (w_state_d == SETTLE)) begin
      r_load_ok <= 1'b1;
    end else if ((r_state == LOAD) && (w_state_d == ERR)) begin
      r_load_err <= 1'b1;
    end
  end

  // Registered ROM write port; strobes last exactly one cycle per accepted byte.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_we       <= 3'b000;
      r_rom_addr <= 14'd0;
      r_rom_data <= 8'd0;
    end else begin
      r_we <= w_rom_wr ? w_region : 3'b000;
      if (w_rom_wr) begin
        r_rom_addr <= w_offset;
        r_rom_data <= dn_data;
      end
    end
  end

  // DIP capture, independent of the load state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_dip1 <= DIP_DEFAULT;
      r_dip2 <= DIP_DEFAULT;
    end else if (w_dip_wr) begin
      if (dn_addr[2:0] == 3'd0) r_dip1 <= dn_data;
      if (dn_addr[2:0] == 3'd1) r_dip2 <= dn_data;
    end
  end

  assign cpu_rom_we = r_we[REG_CPU];
  assign chr_rom_we = r_we[REG_CHR];
  assign spr_rom_we = r_we[REG_SPR];
  assign rom_addr   = r_rom_addr;
  assign rom_data   = r_rom_data;
  assign dipsw1     = r_dip1;
  assign dipsw2     = r_dip2;
  assign core_reset = (r_state != RUN);
  assign load_ok    = r_load_ok;
  assign load_err   = r_load_err;

endmodule
